md_unit_ctrl: RTL and testbench

- Multiply/divide unit plus its sequencer for the 5-stage pipeline, placed in the E stage beside the ALU.
- Executes mult/multu/div/divu over a multi-cycle busy window and holds the HI/LO registers.
- Serves mthi/mtlo/mfhi/mflo.
- Generates the D-stage stall request when an md-class instruction meets an in-flight operation.

---
 rtl/md_unit_ctrl_if.sv | 39 +++
 rtl/md_unit_ctrl.sv | 162 ++++++++++++++++
 tb/tb_md_unit_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_ctrl_if.sv
// ---------------------------------------------------------------------------
// md_unit_ctrl_if
//   Bundles the E-stage request and result signals of the multiply/divide
//   unit.
//   master : pipeline side (drives start/op/operands/d_md_use)
//   slave  : md_unit_ctrl (drives busy/stall_md/rd_data/hi/lo)
// Signals:
//   start     E-stage instruction is an md operation; qualifies op
//   op        0 NONE 1 MULT 2 MULTU 3 DIV 4 DIVU 5 MTHI 6 MTLO 7 MFHI 8 MFLO
//   rs_val    forwarded rs operand
//   rt_val    forwarded rt operand
//   d_md_use  D-stage instruction is an md-class op
//   busy      multi-cycle operation in flight
//   stall_md  stall request to the hazard logic
//   rd_data   HI when op==MFHI, LO otherwise (combinational)
//   hi, lo    architectural HI/LO registers
// ---------------------------------------------------------------------------
interface md_unit_ctrl_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic        busy;
    logic        stall_md;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, d_md_use,
        input  busy, stall_md, rd_data, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, d_md_use,
        output busy, stall_md, rd_data, hi, lo
    );
endinterface

// File: rtl/md_unit_ctrl.sv
// ---------------------------------------------------------------------------
// md_unit_ctrl
//   Multiply/divide unit and sequencer for the E stage. Runs mult/multu/
//   div/divu over a fixed busy window, owns HI/LO, serves mthi/mtlo/mfhi/
//   mflo and raises the D-stage stall for md-class instructions that would
//   collide with an operation in flight.
// Parameters:
//   MUL_LAT  busy cycles for mult/multu (1..255)
//   DIV_LAT  busy cycles for div/divu   (1..255)
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high reset
//   cancel   abort in-flight operation (only with MDU_CANCEL_EN defined)
//   bus      md_unit_ctrl_if.slave (request, stall and HI/LO result bus)
// Build option:
//   MDU_CANCEL_EN  adds the cancel port; without it every started
//                  operation runs to completion.
// ---------------------------------------------------------------------------
module md_unit_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic           clk,
    input  logic           reset,
`ifdef MDU_CANCEL_EN
    input  logic           cancel,
`endif
    md_unit_ctrl_if.slave  bus
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL_BUSY = 2'd1;
    localparam logic [1:0] S_DIV_BUSY = 2'd2;

    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        op_signed;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        cancel_now;
    logic        issue_md;
    logic        busy_now;

`ifdef MDU_CANCEL_EN
    assign cancel_now = cancel;
`else
    assign cancel_now = 1'b0;
`endif

    assign busy_now = (state != S_IDLE);
    assign issue_md = bus.start && (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);

    // The issue term covers the cycle in which the operation enters E, so a
    // following md instruction never reaches E while the unit is busy.
    assign bus.stall_md = bus.d_md_use && (busy_now || issue_md);
    assign bus.busy     = busy_now;
    assign bus.rd_data  = (bus.op == OP_MFHI) ? hi_q : lo_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    // Result datapath, evaluated from the latched operands. Signed cases are
    // handled as magnitudes so one unsigned multiplier/divider serves both.
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] prod;

    // NOTE: every always_comb output gets a value on every path (here by
    // plain assignment at the top) so no latch can be inferred.
    always_comb begin
        a_neg = op_signed && opa[31];
        b_neg = op_signed && opb[31];
        a_mag = a_neg ? -opa : opa;
        b_mag = b_neg ? -opb : opb;
        // A zero divisor never writes back; substituting 1 keeps the
        // divider output defined instead of X in simulation.
        b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negated
        // wraps back to 0x80000000 with remainder 0.
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
        // Sign-extending to 64 bits makes the low 64 product bits correct
        // for both signed and unsigned multiply.
        prod  = {{32{a_neg ^ 1'b0 ? 1'b1 : 1'b0}}, opa} * {{32{b_neg}}, opb};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    // NOTE: the operand latches are reset along with the control state;
    // they are plain flops, not a memory array, so resetting them is cheap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            opa       <= 32'd0;
            opb       <= 32'd0;
            op_signed <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else if (busy_now) begin
            // A start while busy is illegal and deliberately ignored here.
            if (cancel_now) begin
                state <= S_IDLE;
                cnt   <= 8'd0;
            end else if (cnt == 8'd1) begin
                state <= S_IDLE;
                cnt   <= 8'd0;
                if (state == S_MUL_BUSY) begin
                    {hi_q, lo_q} <= prod;
                end else if (opb != 32'd0) begin
                    hi_q <= rem;
                    lo_q <= quot;
                end
            end else begin
                cnt <= cnt - 8'd1;
            end
        end else if (bus.start && !cancel_now) begin
            case (bus.op)
                OP_MULT, OP_MULTU: begin
                    opa       <= bus.rs_val;
                    opb       <= bus.rt_val;
                    op_signed <= (bus.op == OP_MULT);
                    cnt       <= MUL_CNT;
                    state     <= S_MUL_BUSY;
                end
                OP_DIV, OP_DIVU: begin
                    opa       <= bus.rs_val;
                    opb       <= bus.rt_val;
                    op_signed <= (bus.op == OP_DIV);
                    cnt       <= DIV_CNT;
                    state     <= S_DIV_BUSY;
                end
                OP_MTHI: hi_q <= bus.rs_val;
                OP_MTLO: lo_q <= bus.rs_val;
                default: ;  // MFHI/MFLO, NONE and undefined ops change nothing
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_md_unit_ctrl
//   Self-checking bench for md_unit_ctrl. Expected HI/LO come from a
//   64-bit arithmetic model; busy/stall windows from the configured
//   latencies. Directed steps follow the test plan, then random operations.
// ---------------------------------------------------------------------------
module tb_md_unit_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic reset;
`ifdef MDU_CANCEL_EN
    logic cancel;
`endif

    always #5 clk = ~clk;

    md_unit_ctrl_if bus ();

    md_unit_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef MDU_CANCEL_EN
        .cancel (cancel),
`endif
        .bus    (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [3:0] o);
        if (o == 4'd1 || o == 4'd2) return MUL_LAT;
        if (o == 4'd3 || o == 4'd4) return DIV_LAT;
        return 0;
    endfunction

    // Architectural effect of one completed operation on the HI/LO model.
    function automatic void model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (o)
            4'd1: {m_hi, m_lo} = 64'(sa * sb);
            4'd2: {m_hi, m_lo} = ua * ub;
            4'd3: if (b != 32'd0) begin
                m_lo = 32'(sa / sb);
                m_hi = 32'(sa % sb);
            end
            4'd4: if (b != 32'd0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    // Issue one operation at a negedge and follow it to completion,
    // checking busy/stall every cycle and HI/LO/rd_data afterwards.
    // poke drives an illegal start in the second busy cycle.
    task automatic do_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input bit poke);
        int          lat;
        logic [31:0] prev_hi, prev_lo;
        lat     = lat_of(o);
        prev_hi = m_hi;
        prev_lo = m_lo;
        bus.start    = 1'b1;
        bus.op       = o;
        bus.rs_val   = a;
        bus.rt_val   = b;
        bus.d_md_use = use_d;
        #1;
        check("stall_issue", 32'(bus.stall_md), 32'(use_d && lat != 0));
        if (o == 4'd7) check("mfhi_rd", bus.rd_data, m_hi);
        if (o == 4'd8) check("mflo_rd", bus.rd_data, m_lo);
        @(negedge clk);
        model_apply(o, a, b);
        for (int k = 1; k <= lat; k++) begin
            bus.rs_val = $urandom;
            bus.rt_val = $urandom;
            if (poke && k == 2) begin
                bus.start = 1'b1;
                bus.op    = 4'($urandom_range(1, 8));
            end else begin
                bus.start = 1'b0;
                bus.op    = 4'd0;
            end
            #1;
            check("busy_window", 32'(bus.busy), 32'd1);
            check("stall_busy", 32'(bus.stall_md), 32'(use_d));
            if (k == lat) begin
                check("hi_before_wb", bus.hi, prev_hi);
                check("lo_before_wb", bus.lo, prev_lo);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.op    = 4'd0;
        #1;
        check("busy_done", 32'(bus.busy), 32'd0);
        check("stall_done", 32'(bus.stall_md), 32'd0);
        check("hi", bus.hi, m_hi);
        check("lo", bus.lo, m_lo);
        bus.op = 4'd7;
        #1;
        check("rd_hi", bus.rd_data, m_hi);
        bus.op = 4'd8;
        #1;
        check("rd_lo", bus.rd_data, m_lo);
        bus.op = 4'd0;
        bus.d_md_use = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        reset        = 1'b1;
`ifdef MDU_CANCEL_EN
        cancel       = 1'b0;
`endif
        bus.start    = 1'b0;
        bus.op       = 4'd0;
        bus.rs_val   = 32'd0;
        bus.rt_val   = 32'd0;
        bus.d_md_use = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_stall", 32'(bus.stall_md), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Signed and unsigned multiply.
        do_md(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);
        do_md(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h0000_0001);

        // Signed divide and the overflow corner.
        do_md(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        do_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("divovf_lo", bus.lo, 32'h8000_0000);
        check("divovf_hi", bus.hi, 32'h0000_0000);

        // Divide by zero leaves HI/LO alone.
        do_md(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        do_md(4'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
        do_md(4'd4, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
        do_md(4'd3, 32'h0000_0123, 32'd0, 1'b0, 1'b0);
        bus.op = 4'd7;
        #1;
        check("dz_mfhi", bus.rd_data, 32'h1234_5678);
        bus.op = 4'd8;
        #1;
        check("dz_mflo", bus.rd_data, 32'h9ABC_DEF0);
        bus.op = 4'd0;
        @(negedge clk);

        // Stall window with d_md_use held, plus an illegal start mid-busy.
        do_md(4'd1, 32'h0001_0003, 32'h0000_0007, 1'b1, 1'b1);
        do_md(4'd4, 32'd100, 32'd7, 1'b1, 1'b1);

        // NONE and undefined opcodes have no effect.
        do_md(4'd0, 32'hDEAD_BEEF, 32'd1, 1'b1, 1'b0);
        do_md(4'd9, 32'hDEAD_BEEF, 32'd1, 1'b1, 1'b0);
        do_md(4'd15, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);

`ifdef MDU_CANCEL_EN
        // Cancel in the third busy cycle of a DIV: no writeback.
        bus.start  = 1'b1;
        bus.op     = 4'd3;
        bus.rs_val = 32'd1000;
        bus.rt_val = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 4'd0;
        @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        #1;
        check("cancel_busy3", 32'(bus.busy), 32'd1);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("cancel_busy", 32'(bus.busy), 32'd0);
        check("cancel_hi", bus.hi, m_hi);
        check("cancel_lo", bus.lo, m_lo);
        repeat (DIV_LAT) @(negedge clk);
        check("cancel_hi_late", bus.hi, m_hi);
        check("cancel_lo_late", bus.lo, m_lo);
        // Cancel in IDLE suppresses a same-edge MTHI.
        bus.start  = 1'b1;
        bus.op     = 4'd5;
        bus.rs_val = 32'h5555_AAAA;
        cancel     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 4'd0;
        cancel    = 1'b0;
        #1;
        check("cancel_mthi", bus.hi, m_hi);
        check("cancel_idle_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
`endif

        // Asynchronous reset in the middle of a MULT.
        do_md(4'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        do_md(4'd6, 32'hFEED_FACE, 32'd0, 1'b0, 1'b0);
        bus.start  = 1'b1;
        bus.op     = 4'd1;
        bus.rs_val = 32'd7;
        bus.rt_val = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 10));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            do_md(ro, ra, rb, 1'($urandom_range(0, 1)), lat_of(ro) >= 3 && $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
